// File: rtl/weighted_sum_top.sv
// rtl/weighted_sum_top.sv - systolic N-lane signed 18x18 dot product, latency N+3, 1 vector/cycle
// Lane i is skewed by i cycles so its product meets the partial sum from lane i-1 in the post-add chain.

module fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
        end else begin
          stage[0] <= din;
          for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate
endmodule

module weighted_sum_top #(
  parameter int N = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [18*N-1:0]   x,
  input  logic [18*N-1:0]   w,
  output logic [47:0]       sum
);
  logic [N-1:0][35:0]  skewed;
  logic signed [17:0]  a_x [N];
  logic signed [17:0]  a_w [N];
  logic signed [35:0]  m   [N];
  logic signed [47:0]  p   [N];

  // Lane 0 needs no skew, so it bypasses the delay line entirely.
  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      if (i == 0) begin : g_noskew
        assign skewed[i] = {x[18*i +: 18], w[18*i +: 18]};
      end else begin : g_skew
        fifo #(.WIDTH(36), .DEPTH(i)) u_skew (
          .clk  (clk),
          .rst_n(rst_n),
          .din  ({x[18*i +: 18], w[18*i +: 18]}),
          .dout (skewed[i])
        );
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        a_x[i] <= '0;
        a_w[i] <= '0;
        m[i]   <= '0;
        p[i]   <= '0;
      end
      sum <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        a_x[i] <= $signed(skewed[i][35:18]);
        a_w[i] <= $signed(skewed[i][17:0]);
        m[i]   <= a_x[i] * a_w[i];
      end
      p[0] <= {{12{m[0][35]}}, m[0]};
      for (int i = 1; i < N; i++) p[i] <= p[i-1] + {{12{m[i][35]}}, m[i]};
      sum <= p[N-1];
    end
  end
endmodule

// File: tb/tb_weighted_sum_top.sv
// tb/tb_weighted_sum_top.sv - directed self-checking bench for weighted_sum_top
// A reference pipeline of depth N+3 carries the expected dot product of each applied vector.

module tb_weighted_sum_top;
  localparam int N = 16;
  localparam int D = N + 3;

  logic            clk;
  logic            rst_n;
  logic [18*N-1:0] x;
  logic [18*N-1:0] w;
  logic [47:0]     sum;

  logic [47:0] pipe [D];
  int checks = 0;
  int errors = 0;

  weighted_sum_top #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .x    (x),
    .w    (w),
    .sum  (sum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic logic [47:0] dot();
    longint s = 0;
    for (int i = 0; i < N; i++)
      s += longint'($signed(x[18*i +: 18])) * longint'($signed(w[18*i +: 18]));
    return s[47:0];
  endfunction

  task automatic clear_model();
    for (int k = 0; k < D; k++) pipe[k] = '0;
  endtask

  task automatic set_all(input int xv, input int wv);
    logic [31:0] xs, ws;
    xs = xv;
    ws = wv;
    for (int i = 0; i < N; i++) begin
      x[18*i +: 18] = xs[17:0];
      w[18*i +: 18] = ws[17:0];
    end
  endtask

  // One clock edge: advance the reference model, then compare just after the edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst_n) begin
      clear_model();
    end else begin
      for (int k = D - 1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = dot();
    end
    #1;
    check(tag, sum, pipe[D-1]);
  endtask

  initial begin
    clear_model();
    rst_n = 1'b1;
    x = '0;
    w = '0;
    #1 rst_n = 1'b0;

    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) begin
        x[18*i +: 18] = 18'($urandom);
        w[18*i +: 18] = 18'($urandom);
      end
      tick("reset_hold");
      check("reset_zero", sum, 48'd0);
    end

    set_all(0, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) tick("zeros_after_release");
    check("zeros_const", sum, 48'd0);

    set_all(10, 2);
    for (int c = 0; c < D + 3; c++) begin
      tick("const_model");
      if (c >= N + 2) check("const_320", sum, 48'd320);
    end

    for (int c = 0; c < 100; c++) begin
      if (c == 50) begin
        rst_n = 1'b0;
        #1;
        check("async_reset", sum, 48'd0);
        clear_model();
      end
      if (c == 52) rst_n = 1'b1;
      set_all(10 + c, 2 + c);
      tick("ramp");
    end

    set_all(-131072, -131072);
    for (int c = 0; c < D; c++) tick("neg_neg_model");
    check("neg_neg", sum, 48'd274877906944);

    set_all(-131072, 131071);
    for (int c = 0; c < D; c++) tick("neg_pos_model");
    check("neg_pos", sum, 48'(-64'sd274875809792));

    for (int k = 0; k < N; k++) begin
      set_all(0, 0);
      x[18*k +: 18] = 18'd3;
      w[18*k +: 18] = 18'(-5);
      tick("lane_model");
      set_all(0, 0);
      for (int c = 1; c < D; c++) tick("lane_model");
      check($sformatf("lane_%0d", k), sum, 48'(-64'sd15));
      tick("lane_after");
      check($sformatf("lane_%0d_clear", k), sum, 48'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/weighted_sum_top.md
Name: weighted_sum_top

Overview:
- Fully pipelined, systolic dot-product engine for the single-layer perceptron datapath.
- Each cycle it accepts N signed 18-bit inputs x[i] and N signed 18-bit weights w[i]. After a fixed latency it outputs the 48-bit sum of x[i]*w[i] for that cycle's vector.
- Structure is a DSP48-style cascade: per-lane input skew, multiply, and a chained post-add. Lane skew uses an internal parameterised delay-line submodule (`fifo`: WIDTH, DEPTH; pure shift register, no handshake).

Parameters:
- N, 16, number of lanes (x/w pairs); legal range 1..64.

Ports:
- clk, input, 1, single rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- x, input, 18*N, packed inputs; lane i = x[18*i+17 : 18*i]; signed two's complement.
- w, input, 18*N, packed weights; same lane packing; signed two's complement.
- sum, output, 48, registered signed dot product.

Behaviour:
- Reset:
  - rst_n low immediately clears every pipeline register, skew register and delay-line stage. sum = 0 while rst_n is low.
  - Release is synchronous to the next rising edge.
  - After release, sum stays 0 until the first post-reset vector emerges (zeros propagate through the pipeline).
- No handshake, no valid signal. A new vector is accepted every cycle; throughput is 1 vector/cycle.
- Latency:
  - A vector present on x/w at rising edge t appears on sum right after rising edge t+N+2, i.e. N+3 register stages on every path.
  - Equivalently, a bench that delays its expected operands through a DEPTH=N+3 shift register sees sum match on every edge.
- Lane i datapath:
  - Skew: x[i] and w[i] are delayed i extra cycles (delay-line DEPTH=i; lane 0 has none).
  - Input register A/B.
  - Multiply: signed 18x18 -> 36-bit product, registered (M).
  - Post-add: P[i] = P[i-1] + sign_extend48(M[i]), registered; P[-1] = 0.
  - sum = P[N-1].
- Arithmetic:
  - Products are exact.
  - Accumulation is modulo 2^48 (two's complement wrap, no saturation, no overflow flag).
  - N <= 64 cannot overflow for any 18-bit operands, but the wrap is still defined.
- Delay-line submodule `fifo`:
  - Shift register of DEPTH stages of WIDTH bits.
  - out = in delayed DEPTH cycles.
  - DEPTH=0 is a wire.
  - Async clear on rst_n.
- Mid-operation reset: all in-flight vectors are discarded. The output resumes N+3 cycles after the first post-release vector; intermediate outputs are 0.
- Inputs change only between edges; there are no combinational paths from x/w to sum.

Test Plan:
- Reset:
  - Hold rst_n low with random x/w -> sum = 0 throughout.
  - Release, drive all-zero vectors -> sum stays 0.
- Constant vector:
  - Drive x lanes = 10, w lanes = 2 with N=16, held steady.
  - sum = 320 from edge N+2 after first application onward.
  - Earlier edges show 0 or partial sums only before the first full-latency edge.
- Ramp:
  - Start x=10, w=2, incrementing both by 1 per cycle on all lanes.
  - Every edge, sum = N*x_d*w_d, where x_d/w_d are the operands delayed N+3 cycles.
  - Zero mismatches over 100 cycles.
- Signed/extremes:
  - All lanes x = -131072, w = -131072 -> sum = N*2^34 (N=16: 274877906944).
  - x = -131072, w = 131071 -> sum = -N*17179738112.
- Lane independence:
  - Only lane k nonzero (x=3, w=-5), others 0, for each k in 0..N-1 -> sum = -15 at the same latency N+3 for every k.
- Reset mid-stream: assert rst_n for 2 cycles during the ramp.
  - sum goes to 0 asynchronously.
  - After release, the first nonzero matching value appears N+3 cycles after the first post-release vector.
